ifid_stage: RTL and testbench

- IF/ID pipeline stage between instruction fetch and decode; it produces the PC, PC+4 and instruction words that decode turns into ID/EX register contents.
- Two-entry skid buffer (main + skid) with valid/ready on both sides, so fetch back-pressure is fully registered.
- Supports flush on EX-stage redirect (taken branch, jal, jalr).
- Presents pre-extracted opcode/funct3/rd/rs1/rs2 fields so the decoder and hazard unit do not re-slice the instruction.

---
 rtl/ifid_stage.sv | 219 +++++++++++++++++++++
 tb/tb_ifid_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_stage.sv
// ---------------------------------------------------------------------------
// ifid_stage
//
// Purpose:
//   IF/ID pipeline register between instruction fetch and decode. Holds up to
//   two beats (main + skid) so that the fetch-side ready is a registered
//   signal. Beats leave in acceptance order. An EX-stage redirect (flush)
//   kills everything held plus any beat arriving in the same cycle.
//   Decoder fields (opcode/funct3/rd/rs1/rs2) are pre-sliced from id_instr.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   if_valid/if_ready fetch-side handshake (if_ready = NOT skid valid)
//   if_pc/if_plusFour/if_instr   fetched beat
//   flush             redirect from EX, kills held and arriving beats
//   id_valid/id_ready decode-side handshake
//   id_pc/id_plusFour/id_instr   main entry contents (NOP_INSTR when empty)
//   id_opcode/id_funct3/id_rd/id_rs1/id_rs2  slices of id_instr
//
// Optional feature (macro IFID_PERF_EN):
//   perf_stall_cnt    cycles with id_valid=1 and id_ready=0
//   perf_flush_cnt    number of entries killed by flushes
// ---------------------------------------------------------------------------
module ifid_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_plusFour,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_plusFour,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    // State encodes {main_valid, skid_valid}; 2'b01 is illegal.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   main_pc_q, main_pc_d;
    logic [XLEN-1:0]   main_p4_q, main_p4_d;
    logic [31:0]       main_instr_q, main_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   skid_p4_q, skid_p4_d;
    logic [31:0]       skid_instr_q, skid_instr_d;

    logic              main_valid_s;
    logic              skid_valid_s;
    logic              in_fire_s;
    logic              out_fire_s;

    assign main_valid_s = state_q[1];
    assign skid_valid_s = state_q[0];

    // Ready is taken straight from the skid flag, so it is registered.
    assign if_ready    = ~skid_valid_s;
    assign id_valid    = main_valid_s;
    assign id_pc       = main_pc_q;
    assign id_plusFour = main_p4_q;
    // main_instr_q is forced to NOP_INSTR whenever main is emptied.
    assign id_instr    = main_instr_q;

    assign in_fire_s  = if_valid & if_ready;
    assign out_fire_s = id_valid & id_ready;

    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_rd     = id_instr[11:7];
    assign id_rs1    = id_instr[19:15];
    assign id_rs2    = id_instr[24:20];

    // Next-state and datapath selection for the two-entry buffer.
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_p4_d    = main_p4_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_p4_d    = skid_p4_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // PC fields are left as-is; only validity and the instruction
            // word are cleared so the bubble decodes as a NOP.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d      = ST_ONE;
                        main_pc_d    = if_pc;
                        main_p4_d    = if_plusFour;
                        main_instr_d = if_instr;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (out_fire_s && in_fire_s) begin
                        state_d      = ST_ONE;
                        main_pc_d    = if_pc;
                        main_p4_d    = if_plusFour;
                        main_instr_d = if_instr;
                    end else if (out_fire_s) begin
                        state_d      = ST_EMPTY;
                        main_instr_d = NOP_INSTR;
                    end else if (in_fire_s) begin
                        state_d      = ST_FULL;
                        skid_pc_d    = if_pc;
                        skid_p4_d    = if_plusFour;
                        skid_instr_d = if_instr;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // if_ready is low here, so no new beat can arrive.
                    if (out_fire_s) begin
                        state_d      = ST_ONE;
                        main_pc_d    = skid_pc_q;
                        main_p4_d    = skid_p4_q;
                        main_instr_d = skid_instr_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    // State and entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= {XLEN{1'b0}};
            main_p4_q    <= {XLEN{1'b0}};
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= {XLEN{1'b0}};
            skid_p4_q    <= {XLEN{1'b0}};
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_p4_q    <= main_p4_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_p4_q    <= skid_p4_d;
            skid_instr_q <= skid_instr_d;
        end
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] kill_num_s;

    // Entries killed by a flush: held entries plus an arriving beat.
    assign kill_num_s = {31'd0, main_valid_s} + {31'd0, skid_valid_s}
                      + {31'd0, in_fire_s};

    // Counter next values; both wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_valid && !id_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush) begin
            flush_cnt_d = flush_cnt_q + kill_num_s;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
module tb_ifid_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_plusFour;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_plusFour;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
`ifdef IFID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks;
    int n_fails;

    ifid_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_plusFour (if_plusFour),
        .if_instr    (if_instr),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_plusFour (id_plusFour),
        .id_instr    (id_instr),
        .id_opcode   (id_opcode),
        .id_funct3   (id_funct3),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2)
`ifdef IFID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        if_valid    = v;
        if_pc       = pc;
        if_plusFour = pc + 32'd4;
        if_instr    = ins;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check_eq({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        check_eq({tag, "_pc"},    id_pc,             pc);
        check_eq({tag, "_p4"},    id_plusFour,       pc + 32'd4);
        check_eq({tag, "_instr"}, id_instr,          ins);
    endtask

    task automatic expect_bubble(input string tag);
        check_eq({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check_eq({tag, "_instr"}, id_instr,          32'h0000_0013);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        drive(1'b1, 32'h0000_0100, 32'h0010_0093);

        // Reset held two cycles with fetch presenting a beat.
        tick();
        tick();
        expect_bubble("rst");
        check_eq("rst_if_ready", {31'd0, if_ready},  32'd1);
        check_eq("rst_opcode",   {25'd0, id_opcode}, 32'h13);
        check_eq("rst_pc",       id_pc,              32'd0);
        check_eq("rst_p4",       id_plusFour,        32'd0);
        check_eq("rst_rd",       {27'd0, id_rd},     32'd0);
`ifdef IFID_PERF_EN
        check_eq("rst_stall_cnt", perf_stall_cnt, 32'd0);
        check_eq("rst_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        rst = 1'b0;

        // Streaming at full throughput.
        id_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h0050_0093);
        tick();
        expect_beat("s0", 32'h0, 32'h0050_0093);
        drive(1'b1, 32'h4, 32'h00a0_0113);
        tick();
        expect_beat("s1", 32'h4, 32'h00a0_0113);
        check_eq("s1_if_ready", {31'd0, if_ready}, 32'd1);
        drive(1'b1, 32'h8, 32'h0020_81b3);
        tick();
        expect_beat("s2", 32'h8, 32'h0020_81b3);
        check_eq("s2_rd",     {27'd0, id_rd},     32'd3);
        check_eq("s2_rs1",    {27'd0, id_rs1},    32'd1);
        check_eq("s2_rs2",    {27'd0, id_rs2},    32'd2);
        check_eq("s2_opcode", {25'd0, id_opcode}, 32'h33);
        check_eq("s2_funct3", {29'd0, id_funct3}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        expect_bubble("s_drain");

        // Back-pressure: fill main and skid, then release.
        id_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h0010_0213);
        tick();
        expect_beat("bp0", 32'h10, 32'h0010_0213);
        check_eq("bp0_if_ready", {31'd0, if_ready}, 32'd1);
        drive(1'b1, 32'h14, 32'h0020_0293);
        tick();
        expect_beat("bp1", 32'h10, 32'h0010_0213);
        check_eq("bp1_if_ready", {31'd0, if_ready}, 32'd0);
        drive(1'b1, 32'h18, 32'h0030_0313);
        tick();
        expect_beat("bp2_hold", 32'h10, 32'h0010_0213);
        check_eq("bp2_if_ready", {31'd0, if_ready}, 32'd0);
`ifdef IFID_PERF_EN
        check_eq("bp_stall_cnt", perf_stall_cnt, 32'd2);
`endif
        id_ready = 1'b1;
        tick();
        expect_beat("bp3", 32'h14, 32'h0020_0293);
        check_eq("bp3_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        expect_beat("bp4", 32'h18, 32'h0030_0313);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        expect_bubble("bp_drain");

        // Flush while FULL with no arriving beat.
        id_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h0010_0213);
        tick();
        drive(1'b1, 32'h14, 32'h0020_0293);
        tick();
        check_eq("fl_full_if_ready", {31'd0, if_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_bubble("fl_full");
        check_eq("fl_full_if_ready2", {31'd0, if_ready}, 32'd1);
        check_eq("fl_full_pc_kept",   id_pc,             32'h10);
`ifdef IFID_PERF_EN
        check_eq("fl_full_cnt", perf_flush_cnt, 32'd2);
`endif

        // Flush from EMPTY with a simultaneous accepted beat.
        drive(1'b1, 32'h20, 32'h0050_0393);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_bubble("fl_in");
`ifdef IFID_PERF_EN
        check_eq("fl_in_cnt", perf_flush_cnt, 32'd3);
`endif
        drive(1'b1, 32'h40, 32'h0060_0413);
        tick();
        expect_beat("fl_next", 32'h40, 32'h0060_0413);
        drive(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        tick();
        expect_bubble("fl_drain");

        // Reset while FULL with id_ready high.
        id_ready = 1'b0;
        drive(1'b1, 32'h50, 32'h0070_0493);
        tick();
        drive(1'b1, 32'h54, 32'h0080_0513);
        tick();
        check_eq("mr_full_if_ready", {31'd0, if_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        expect_bubble("mr");
        check_eq("mr_if_ready", {31'd0, if_ready}, 32'd1);
        check_eq("mr_pc",       id_pc,             32'd0);
`ifdef IFID_PERF_EN
        check_eq("mr_stall_cnt", perf_stall_cnt, 32'd0);
        check_eq("mr_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mr_no_stale", {31'd0, id_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
